// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: request, result and divider/multiplier handshake bundle for
// the HI/LO sequencer.
//   slave  modport : sequencer side (muldiv_ctrl)
//   master modport : control unit plus external divider/multiplier side
// Signals:
//   op_valid/op_code/rs_val/rt_val/cancel   request from the control unit
//   op_ready/busy/done                       request handshake and status
//   rd_data/rd_valid                         MFHI/MFLO read return
//   div_zero_exc                             divide-by-zero pulse
//   hi/lo                                    architectural HI/LO registers
//   div_*   start/reset/operands out, remainder/quotient/zero flag in
//   mult_*  start/operands out, product words in
interface muldiv_ctrl_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic        div_start;
    logic        div_reset;
    logic [31:0] div_q;
    logic [31:0] div_b;
    logic        div_zero_in;
    logic [31:0] div_hi_in;
    logic [31:0] div_lo_in;
    logic        mult_start;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [31:0] mult_hi_in;
    logic [31:0] mult_lo_in;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        div_zero_exc;

    modport slave (
        input  op_valid, op_code, rs_val, rt_val, cancel,
        input  div_zero_in, div_hi_in, div_lo_in, mult_hi_in, mult_lo_in,
        output op_ready, busy, done, div_start, div_reset, div_q, div_b,
        output mult_start, mult_a, mult_b, hi, lo, rd_data, rd_valid, div_zero_exc
    );

    modport master (
        output op_valid, op_code, rs_val, rt_val, cancel,
        output div_zero_in, div_hi_in, div_lo_in, mult_hi_in, mult_lo_in,
        input  op_ready, busy, done, div_start, div_reset, div_q, div_b,
        input  mult_start, mult_a, mult_b, hi, lo, rd_data, rd_valid, div_zero_exc
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the HI/LO arithmetic unit. Accepts MULT/DIV/
// MFHI/MFLO/MTHI/MTLO requests, launches the external iterative divider or
// multiplier, counts their fixed latency, captures the results into HI/LO
// and holds busy while an operation is in flight. All outputs are registered.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low clear
//   bus    muldiv_ctrl_if.slave (request, status, HI/LO, divider/multiplier)
// Optional build macro MULDIV_ZERO_SHORTCUT_EN: a DIV with a zero divisor
// raises div_zero_exc straight from IDLE without running the divider.
module muldiv_ctrl #(
    parameter int unsigned DIV_CYCLES  = 34,
    parameter int unsigned MULT_CYCLES = 33,
    parameter int unsigned CNT_W       = 6
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        MULT_RUN = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_MFHI = 3'b011,
        OP_MFLO = 3'b100,
        OP_MTHI = 3'b101,
        OP_MTLO = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              div_start_q;
    logic              div_reset_q;
    logic [31:0]       div_q_q;
    logic [31:0]       div_b_q;
    logic              mult_start_q;
    logic [31:0]       mult_a_q;
    logic [31:0]       mult_b_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic              div_zero_exc_q;
    logic              accept;

    // op_ready_q is only ever high in IDLE, so it doubles as the accept gate.
    assign accept = bus.op_valid && op_ready_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            div_start_q    <= 1'b0;
            div_reset_q    <= 1'b0;
            div_q_q        <= '0;
            div_b_q        <= '0;
            mult_start_q   <= 1'b0;
            mult_a_q       <= '0;
            mult_b_q       <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            div_zero_exc_q <= 1'b0;
        end else begin
            // single-cycle pulses default low
            done_q         <= 1'b0;
            div_start_q    <= 1'b0;
            div_reset_q    <= 1'b0;
            mult_start_q   <= 1'b0;
            rd_valid_q     <= 1'b0;
            div_zero_exc_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    op_ready_q <= 1'b1;
                    if (accept) begin
                        case (op_e'(bus.op_code))
                            OP_MULT: begin
                                mult_a_q     <= bus.rs_val;
                                mult_b_q     <= bus.rt_val;
                                cnt_q        <= MULT_LOAD;
                                mult_start_q <= 1'b1;
                                busy_q       <= 1'b1;
                                op_ready_q   <= 1'b0;
                                state_q      <= MULT_RUN;
                            end
                            OP_DIV: begin
`ifdef MULDIV_ZERO_SHORTCUT_EN
                                if (bus.rt_val == '0) begin
                                    div_zero_exc_q <= 1'b1;
                                end else begin
`else
                                begin
`endif
                                    div_q_q     <= bus.rs_val;
                                    div_b_q     <= bus.rt_val;
                                    cnt_q       <= DIV_LOAD;
                                    div_start_q <= 1'b1;
                                    busy_q      <= 1'b1;
                                    op_ready_q  <= 1'b0;
                                    state_q     <= DIV_RUN;
                                end
                            end
                            OP_MFHI: begin
                                rd_data_q  <= hi_q;
                                rd_valid_q <= 1'b1;
                            end
                            OP_MFLO: begin
                                rd_data_q  <= lo_q;
                                rd_valid_q <= 1'b1;
                            end
                            OP_MTHI: hi_q <= bus.rs_val;
                            OP_MTLO: lo_q <= bus.rs_val;
                            default: ;  // NOP and reserved encoding
                        endcase
                    end
                end

                DIV_RUN, MULT_RUN: begin
                    // cancel takes priority over a completion on the same edge
                    if (bus.cancel) begin
                        div_reset_q <= (state_q == DIV_RUN);
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        op_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else if (cnt_q == '0) begin
                        busy_q     <= 1'b0;
                        op_ready_q <= 1'b1;
                        state_q    <= IDLE;
                        if (state_q == MULT_RUN) begin
                            hi_q   <= bus.mult_hi_in;
                            lo_q   <= bus.mult_lo_in;
                            done_q <= 1'b1;
                        end else if (bus.div_zero_in) begin
                            div_zero_exc_q <= 1'b1;
                        end else begin
                            hi_q   <= bus.div_hi_in;
                            lo_q   <= bus.div_lo_in;
                            done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready     = op_ready_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.div_start    = div_start_q;
    assign bus.div_reset    = div_reset_q;
    assign bus.div_q        = div_q_q;
    assign bus.div_b        = div_b_q;
    assign bus.mult_start   = mult_start_q;
    assign bus.mult_a       = mult_a_q;
    assign bus.mult_b       = mult_b_q;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.div_zero_exc = div_zero_exc_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the HI/LO arithmetic unit.
- Accepts MULT/DIV/MFHI/MFLO/MTHI/MTLO requests from the control unit and drives start pulses and operands to the external iterative divider and multiplier.
- Counts their fixed latency, captures results into its architectural HI/LO registers, and raises busy so the control unit stalls.
- Flags divide-by-zero to the exception logic.

Parameters:
- DIV_CYCLES, 34, cycles spent in DIV_RUN (start cycle included) before results are captured.
- MULT_CYCLES, 33, same, for MULT_RUN.
- CNT_W, 6, down-counter width; must hold max(DIV_CYCLES, MULT_CYCLES)-1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when 0.
- op_valid  in  1  request strobe.
- op_code  in  3  000 NOP, 001 MULT, 010 DIV, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 reserved (ignored like NOP).
- rs_val  in  32  DIV dividend / MULT operand A / MTHI-MTLO data.
- rt_val  in  32  DIV divisor / MULT operand B.
- cancel  in  1  abort the in-flight MULT/DIV.
- op_ready  out  1  high only in IDLE; a request is accepted on an edge where op_valid and op_ready are both 1.
- busy  out  1  high in DIV_RUN and MULT_RUN.
- done  out  1  one-cycle pulse after a MULT/DIV completes normally.
- div_start  out  1  start to the divider.
- div_reset  out  1  one-cycle pulse on cancel during DIV_RUN.
- div_q  out  32  latched dividend.
- div_b  out  32  latched divisor.
- div_zero_in  in  1  divider zero flag.
- div_hi_in  in  32  divider remainder.
- div_lo_in  in  32  divider quotient.
- mult_start  out  1  start to the multiplier.
- mult_a  out  32  latched operand A.
- mult_b  out  32  latched operand B.
- mult_hi_in  in  32  product upper word.
- mult_lo_in  in  32  product lower word.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  MFHI/MFLO read data.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.
- div_zero_exc  out  1  one-cycle divide-by-zero pulse.

Behaviour:
- Reset: all outputs 0 (op_ready 0 during reset); state IDLE; counter 0. op_ready is 1 from the first edge after reset release.
- States: IDLE, DIV_RUN, MULT_RUN. All outputs are registered.
- IDLE, DIV accepted:
  - latch div_q=rs_val, div_b=rt_val, load counter=DIV_CYCLES-1, go to DIV_RUN.
  - div_start is 1 during the first DIV_RUN cycle only.
- IDLE, MULT accepted: same pattern with the mult_* ports, MULT_CYCLES and MULT_RUN.
- RUN states: the counter decrements each cycle.
  - On the edge where counter==0: capture results, go IDLE, and pulse done in the next cycle.
  - DIV captures hi=div_hi_in, lo=div_lo_in when div_zero_in=0. If div_zero_in=1, hi/lo are left unchanged, div_zero_exc pulses instead of done, and the state still returns to IDLE.
  - MULT captures hi=mult_hi_in, lo=mult_lo_in.
- Latency: accept edge to hi/lo update is exactly DIV_CYCLES (or MULT_CYCLES) edges.
- MFHI/MFLO accepted: rd_data = hi/lo value at the accept edge; rd_valid is 1 the following cycle. No state change.
- MTHI/MTLO accepted: hi/lo = rs_val on the accept edge.
- NOP and op_code 111: accepted, no effect.
- Requests while busy are not accepted; the requester must hold op_valid, op_code and operands.
- cancel:
  - In a RUN state: go IDLE next edge, hi/lo unchanged, no done. div_reset pulses one cycle when the aborted op was a DIV.
  - In IDLE: ignored.
  - cancel and counter==0 on the same edge: cancel wins, no capture.
- Operand latches hold their values until the next accepted MULT/DIV.
- Async reset mid-operation returns to IDLE with all state cleared; start outputs drop immediately.

Optional Feature:
MULDIV_ZERO_SHORTCUT_EN
- Defined: a DIV accepted with rt_val==0 does not enter DIV_RUN and no div_start is issued. div_zero_exc pulses in the cycle after the accept edge, the state stays IDLE, and hi/lo are unchanged.
- Undefined: a zero-divisor DIV runs the full DIV_CYCLES, and the zero condition is taken from div_zero_in at capture.

Test Plan:
- Reset held low 3 cycles then released -> all outputs 0, op_ready=1 on the first edge after release.
- DIV rs=100, rt=7 accepted at edge 0 (DIV_CYCLES=34), divider model returns hi=2, lo=14 -> div_start high for 1 cycle, busy for 34 cycles, hi=2/lo=14 after edge 34, done pulse in the next cycle.
- DIV rs=-100, rt=7, model returns lo=-14 -> lo=32'hFFFFFFF2; then MFLO -> rd_data=32'hFFFFFFF2 with a rd_valid pulse one cycle after accept.
- MTHI 5, MTLO 9, then DIV rt=0:
  - shortcut defined -> div_zero_exc pulse 1 cycle after accept, no div_start, hi=5/lo=9.
  - shortcut undefined -> exception after 34 cycles, hi=5/lo=9.
- MULT started, cancel asserted in cycle 10 -> IDLE next edge, no done, hi/lo unchanged. cancel coincident with the counter==0 edge -> no capture.
- MFHI held with op_valid during MULT_RUN -> not accepted until IDLE, then rd_data equals the new hi.
